// File: rtl/sample_sender.sv
// sample_sender: streams NUM_WORDS sample-memory words to a UART TX as bytes, MSB byte first.
// Ports: iClock/iReset (sync, active-high); iStart begins a transfer from IDLE;
// oMemAddr/oMemRead/iMemData drive a synchronous-read memory; oTxData/oTxStart/iTxBusy
// form the transmitter handshake; oBusy is high while a transfer runs; oDone pulses at the end.
// Define SAMPLE_SENDER_CHECKSUM_EN to append an XOR checksum byte after the last word.
module sample_sender #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WORDS  = 256
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iStart,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic                  oMemRead,
  input  logic [DATA_WIDTH-1:0] iMemData,
  output logic [7:0]            oTxData,
  output logic                  oTxStart,
  input  logic                  iTxBusy,
  output logic                  oBusy,
  output logic                  oDone
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW = $clog2(BYTES + 1);
  typedef enum logic [3:0] {
    IDLE, READ, LOAD, TX_REQ, TX_GAP, TX_WAIT, NEXT,
`ifdef SAMPLE_SENDER_CHECKSUM_EN
    CSUM,
`endif
    FINISH
  } state_t;
  state_t state, next;
  logic [ADDR_WIDTH-1:0] index;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic last, mem_read_n, tx_start_n, busy_n, done_n, wait_end;
  assign last = index == ADDR_WIDTH'(NUM_WORDS - 1);
  assign oMemAddr = index;
`ifdef SAMPLE_SENDER_CHECKSUM_EN
  logic [7:0] acc;
  logic csum_sent;
  // once the checksum byte has gone out, the byte loop exits straight to FINISH
  assign wait_end = csum_sent;
`else
  assign wait_end = 1'b0;
`endif
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= IDLE;
      index <= '0;
      cnt <= '0;
      shreg <= '0;
      oMemRead <= 1'b0;
      oTxStart <= 1'b0;
      oTxData <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
`ifdef SAMPLE_SENDER_CHECKSUM_EN
      acc <= '0;
      csum_sent <= 1'b0;
`endif
    end else begin
      state <= next;
      oMemRead <= mem_read_n;
      oTxStart <= tx_start_n;
      oBusy <= busy_n;
      oDone <= done_n;
      if (tx_start_n) oTxData <= shreg[DATA_WIDTH-1 -: 8];
      if (state == IDLE && iStart) index <= '0;
      if (state == NEXT && !last) index <= index + 1'b1;
      if (state == LOAD) begin
        shreg <= iMemData;
        cnt <= CW'(BYTES);
      end
      if (state == TX_GAP) begin
        shreg <= shreg << 8;
        cnt <= cnt - 1'b1;
      end
`ifdef SAMPLE_SENDER_CHECKSUM_EN
      if (state == IDLE && iStart) begin
        acc <= '0;
        csum_sent <= 1'b0;
      end
      if (tx_start_n) acc <= acc ^ shreg[DATA_WIDTH-1 -: 8];
      if (state == CSUM) begin
        shreg <= DATA_WIDTH'(acc) << (DATA_WIDTH - 8);
        cnt <= CW'(1);
        csum_sent <= 1'b1;
      end
`endif
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = iStart ? READ : IDLE;
      READ:    next = LOAD;
      LOAD:    next = TX_REQ;
      TX_REQ:  next = iTxBusy ? TX_REQ : TX_GAP;
      TX_GAP:  next = TX_WAIT;
      TX_WAIT: next = iTxBusy ? TX_WAIT : cnt != '0 ? TX_REQ : wait_end ? FINISH : NEXT;
`ifdef SAMPLE_SENDER_CHECKSUM_EN
      NEXT:    next = last ? CSUM : READ;
      CSUM:    next = TX_REQ;
`else
      NEXT:    next = last ? FINISH : READ;
`endif
      FINISH:  next = IDLE;
      default: next = IDLE;
    endcase
  end
  // outputs are registered from the upcoming state so they line up with it
  always_comb begin
    mem_read_n = next == READ;
    tx_start_n = state == TX_REQ && !iTxBusy;
    busy_n = next != IDLE && next != FINISH;
    done_n = next == FINISH;
  end
endmodule

// File: tb/tb_sample_sender.sv
// tb_sample_sender: randomized and directed checks of sample_sender against a byte-stream model.
module tb_sample_sender;
  logic clk = 0, rst = 1, start = 0, hold = 0;
  logic mem_read, tx_start, tx_busy, busy, done;
  logic [7:0] addr, tx_data;
  logic [15:0] mem_data;
  logic [15:0] mem [4];
  int bcnt = 0;
  int checks = 0, failures = 0, ndone = 0, viol = 0, done_busy = 0;
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int addrs [$];

  always #5 clk = ~clk;

  sample_sender #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_WORDS(4)) dut (
    .iClock(clk), .iReset(rst), .iStart(start),
    .oMemAddr(addr), .oMemRead(mem_read), .iMemData(mem_data),
    .oTxData(tx_data), .oTxStart(tx_start), .iTxBusy(tx_busy),
    .oBusy(busy), .oDone(done)
  );

  always @(posedge clk) begin
    if (mem_read) mem_data <= mem[addr[1:0]];
    if (tx_start) bcnt <= 10;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0) || hold;

  always @(negedge clk) begin
    if (tx_start) got.push_back(tx_data);
    if (tx_start && tx_busy) viol++;
    if (mem_read) addrs.push_back(int'(addr));
    if (done) ndone++;
    if (done && busy) done_busy++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_expected();
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.delete();
    for (int w = 0; w < 4; w++)
      for (int b = 1; b >= 0; b--) begin
        exp_q.push_back(mem[w][8*b +: 8]);
        cs ^= mem[w][8*b +: 8];
      end
`ifdef SAMPLE_SENDER_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    check("read_strobe", {31'd0, mem_read}, 32'd1);
    check("read_addr0", {24'd0, addr}, 32'd0);
  endtask

  task automatic run(input bit extra, input int hold_cycles);
    int cyc;
    got.delete(); addrs.delete(); ndone = 0; done_busy = 0;
    build_expected();
    hold = hold_cycles > 0;
    pulse_start();
    cyc = 0;
    while (ndone == 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == hold_cycles) hold = 0;
      start = extra && (cyc == 5 || cyc == 40 || cyc == 77);
    end
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    check("done_count", ndone, 1);
    check("done_with_busy_low", done_busy, 0);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("byte_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("byte%0d", i), i < got.size() ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
    check("addr_count", addrs.size(), 4);
    for (int i = 0; i < addrs.size(); i++) check($sformatf("addr%0d", i), addrs[i], i);
    check("no_start_while_busy", viol, 0);
  endtask

  task automatic load_directed();
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0000; mem[3] = 16'hFFFF;
  endtask

  initial begin
    int cyc;
    load_directed();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {24'd0, addr, tx_data, mem_read, tx_start, busy, done}, 32'd0);
    rst = 0;
    run(0, 0);
`ifdef SAMPLE_SENDER_CHECKSUM_EN
    check("checksum_directed", {24'd0, exp_q[8]}, 32'h40);
`endif
    run(0, 20);
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 4; w++) mem[w] = 16'($urandom);
      run(r == 1, r == 2 ? int'($urandom_range(5, 30)) : 0);
    end
    load_directed();
    got.delete(); ndone = 0;
    pulse_start();
    cyc = 0;
    while (got.size() < 3 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reached_third_byte", got.size(), 3);
    rst = 1;
    @(posedge clk); #1;
    check("reset_mid_outputs", {24'd0, addr, tx_data, mem_read, tx_start, busy, done}, 32'd0);
    rst = 0;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_abort", ndone, 0);
    check("no_tx_after_abort", got.size(), 3);
    run(0, 0);
    check("restart_first_byte", {24'd0, got.size() > 0 ? got[0] : 8'h00}, 32'h12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
